// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: operand width,
// iteration count and the controller state encoding.
package mult_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
    localparam int ITER  = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/adder4_cout.sv
// 4-bit ripple-carry adder built from gate-level full adders; the final
// carry-out is exposed so the multiplier never loses the ninth bit.
module adder4_cout
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] half;

    assign carry[0] = cin_i;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign half[gi]      = a_i[gi] ^ b_i[gi];
            assign sum_o[gi]     = half[gi] ^ carry[gi];
            assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & half[gi]);
        end
    endgenerate

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 4x4 unsigned multiplier: one shift-and-add step per clock
// through a single shared adder, 8-bit product held until the next start.
module shift_add_mult_ctrl
    import mult_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [1:0]         state_q,   state_d;
    logic [WIDTH-1:0]   m_q,       m_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [WIDTH-1:0]   q_q,       q_d;
    logic               c_q,       c_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               sum_cout;

    assign addend = q_q[0] ? m_q : '0;

    adder4_cout u_adder (
        .a_i    (acc_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (sum_cout)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Right shift of {carry, sum, Q}: the carry-out lands in ACC[3].
                {c_d, acc_d, q_d} = {1'b0, sum_cout, sum, q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    product_d = {acc_d, q_d};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // C is architecturally visible state but always shifts out as zero.
    logic carry_unused;
    assign carry_unused = c_q;

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed and exhaustive bench for shift_add_mult_ctrl: vector table,
// ignored-start, asynchronous mid-run reset and all 256 operand pairs.
module tb_shift_add_mult_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks;
    int errors;

    shift_add_mult_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        bit         ign;
        string      name;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issues one operation from an IDLE negedge and returns at the first
    // IDLE negedge after done. With ign set, start stays high with F*F
    // operands through RUN and DONE and must be ignored.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb,
                         input logic [7:0] exp, input bit ign, input string nm,
                         input bit verbose);
        int  busy_cnt;
        int  lat;
        bit  seen_done;
        bit  overlap;
        logic [7:0] prod_at_done;
        busy_cnt = 0;
        lat = 0;
        seen_done = 1'b0;
        overlap = 1'b0;
        prod_at_done = 8'hxx;
        check({nm, " idle_before"}, {30'd0, busy, done}, 32'd0);
        start = 1'b1;
        a = ta;
        b = tb;
        @(negedge clk);
        if (ign) begin
            a = 4'hF;
            b = 4'hF;
        end else begin
            start = 1'b0;
            a = 4'($urandom);
            b = 4'($urandom);
        end
        for (int i = 1; i <= 10; i++) begin
            if (!seen_done) begin
                if (busy) busy_cnt++;
                if (busy && done) overlap = 1'b1;
                if (done) begin
                    seen_done = 1'b1;
                    lat = i;
                    prod_at_done = product;
                end else begin
                    @(negedge clk);
                end
            end
        end
        check({nm, " done_latency"}, 32'(lat), 32'd5);
        check({nm, " busy_cycles"}, 32'(busy_cnt), 32'd4);
        check({nm, " busy_done_overlap"}, 32'(overlap), 32'd0);
        check({nm, " product"}, {24'd0, prod_at_done}, {24'd0, exp});
        start = 1'b0;
        @(negedge clk);
        check({nm, " done_one_cycle"}, {30'd0, busy, done}, 32'd0);
        check({nm, " product_held"}, {24'd0, product}, {24'd0, exp});
        if (verbose)
            $display("op %s: a=%h b=%h product=%h expected=%h latency=%0d busy=%0d",
                     nm, ta, tb, prod_at_done, exp, lat, busy_cnt);
    endtask

    initial begin
        int  rst_busy;
        int  rst_done;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 4'h0;
        b = 4'h0;

        vecs[0] = '{a: 4'h7, b: 4'h3, exp: 8'h15, ign: 1'b0, name: "7x3"};
        vecs[1] = '{a: 4'hF, b: 4'hF, exp: 8'hE1, ign: 1'b0, name: "FxF"};
        vecs[2] = '{a: 4'h0, b: 4'hF, exp: 8'h00, ign: 1'b0, name: "0xF"};
        vecs[3] = '{a: 4'h9, b: 4'h0, exp: 8'h00, ign: 1'b0, name: "9x0"};
        vecs[4] = '{a: 4'h5, b: 4'h6, exp: 8'h1E, ign: 1'b1, name: "5x6_start_in_run"};

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset product", {24'd0, product}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle no start busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].ign, vecs[i].name, 1'b1);
        end
        // start was dropped in IDLE after the ignored-start run: nothing queued.
        @(negedge clk);
        check("no queued start", {31'd0, busy}, 32'd0);
        check("product after ignore", {24'd0, product}, 32'h1E);

        // Asynchronous reset between edges while in RUN.
        start = 1'b1;
        a = 4'hA;
        b = 4'hB;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrun busy before reset", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset done", {31'd0, done}, 32'd0);
        check("async reset product", {24'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rst_busy = 0;
        rst_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) rst_busy++;
            if (done) rst_done++;
        end
        check("post reset no done", 32'(rst_done), 32'd0);
        check("post reset no busy", 32'(rst_busy), 32'd0);
        $display("op reset_midrun: product=%h busy=%0d done=%0d", product, rst_busy, rst_done);
        do_op(4'h3, 4'h4, 8'h0C, 1'b0, "3x4_after_reset", 1'b1);

        // Exhaustive back-to-back: each start in the first IDLE cycle after done.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                logic [3:0] xa;
                logic [3:0] yb;
                logic [7:0] ex;
                xa = 4'(x);
                yb = 4'(y);
                ex = 8'(x * y);
                do_op(xa, yb, ex, 1'b0, $sformatf("ex_%h_%h", xa, yb), 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
